// File: rtl/cy7c67200_hpi_sequencer_pkg.sv
// rtl/cy7c67200_hpi_sequencer_pkg.sv - shared types and constants for the CY7C67200 HPI sequencer
// Contents: FSM state enum, HPI register address constants, phase counter width and load helper.
package cy7c_hpi_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4
    } hpi_state_t;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    localparam int CNT_W = 16;

    // A phase of n cycles is timed by loading n-1 and leaving when the count reaches 0.
    function automatic logic [CNT_W-1:0] cyc_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/cy7c67200_hpi_sequencer_if.sv
// rtl/cy7c67200_hpi_sequencer_if.sv - HPI pin bundle between the sequencer and the EZ-OTG chip
// Signals: hpi_addr, hpi_data_out, hpi_data_oe, hpi_data_in, hpi_cs_n, hpi_rd_n, hpi_wr_n,
//          hpi_rst_n, hpi_int. master = sequencer side, slave = chip/pad side.
interface cy7c67200_hpi_sequencer_if;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic        hpi_rst_n;
    logic        hpi_int;

    modport master (
        output hpi_addr, hpi_data_out, hpi_data_oe, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n,
        input  hpi_data_in, hpi_int
    );

    modport slave (
        input  hpi_addr, hpi_data_out, hpi_data_oe, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n,
        output hpi_data_in, hpi_int
    );
endinterface

// File: rtl/cy7c67200_hpi_sequencer_arb.sv
// rtl/cy7c67200_hpi_sequencer_arb.sv - two-way round-robin arbiter for the HPI sequencer
// Ports: clk, reset (sync, active-high), valid0/valid1 requests, accept (grant taken this cycle),
//        gnt_any (some request pending), gnt_sel (0 = requester 0, 1 = requester 1).
module hpi_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic gnt_any,
    output logic gnt_sel
);
    logic last_grant;

    assign gnt_any = valid0 | valid1;
    // On a tie the requester that did not win last time goes next.
    assign gnt_sel = (valid0 && valid1) ? ~last_grant : valid1;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt_sel;
        end
    end
endmodule

// File: rtl/cy7c67200_hpi_sequencer.sv
// rtl/cy7c67200_hpi_sequencer.sv - CY7C67200 HPI bus cycle sequencer with two arbitrated requesters
// Ports: clk, reset (sync, active-high), soft_reset pulse; per requester N: reqN_valid/write/addr/
//        wdata in, reqN_ready/rvalid out; rdata, busy, int_pulse out; hpi = HPI pin bundle (master).
import cy7c_hpi_pkg::*;

module cy7c67200_hpi_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RST_CYC    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        soft_reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [1:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_rvalid,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [1:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        int_pulse,
    cy7c67200_hpi_sequencer_if.master hpi
);
    hpi_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic        gnt_any, gnt_sel, accept;
    logic        wr_l, sel_l;
    logic [1:0]  addr_l;
    logic [15:0] wdata_l, rdata_q;
    logic        int_s1, int_s2, int_s3, int_q;
    logic        in_access, first_hold_rd;

    hpi_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .accept  (accept),
        .gnt_any (gnt_any),
        .gnt_sel (gnt_sel)
    );

    // A grant is only taken from IDLE and never in a cycle that is being reset or aborted.
    assign accept = (state == ST_IDLE) && gnt_any && !soft_reset && !reset;

    // State register. The counter is preloaded on reset so the power-on RST_N pulse
    // has the same length as one started by soft_reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RST_HOLD;
            cnt   <= cyc_load(RST_CYC);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
        case (state)
            ST_RST_HOLD: begin
                if (cnt == '0) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = cyc_load(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = cyc_load(STROBE_CYC);
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = cyc_load(HOLD_CYC);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RST_HOLD;
                cnt_nxt   = cyc_load(RST_CYC);
            end
        endcase
        if (soft_reset) begin
            state_nxt = ST_RST_HOLD;
            cnt_nxt   = cyc_load(RST_CYC);
        end
    end

    // Output decode
    always_comb begin
        in_access        = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
        first_hold_rd    = (state == ST_HOLD) && (cnt == cyc_load(HOLD_CYC)) && !wr_l && !soft_reset;
        hpi.hpi_cs_n     = !in_access;
        hpi.hpi_rd_n     = !((state == ST_STROBE) && !wr_l);
        hpi.hpi_wr_n     = !((state == ST_STROBE) && wr_l);
        hpi.hpi_data_oe  = in_access && wr_l;
        hpi.hpi_rst_n    = (state != ST_RST_HOLD);
        hpi.hpi_addr     = addr_l;
        hpi.hpi_data_out = wdata_l;
        busy             = (state != ST_IDLE);
        req0_ready       = accept && !gnt_sel;
        req1_ready       = accept && gnt_sel;
        req0_rvalid      = first_hold_rd && !sel_l;
        req1_rvalid      = first_hold_rd && sel_l;
        rdata            = rdata_q;
        int_pulse        = int_q && (state != ST_RST_HOLD);
    end

    // Request capture, read data sampling and INT synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_l    <= 1'b0;
            sel_l   <= 1'b0;
            addr_l  <= 2'd0;
            wdata_l <= 16'h0000;
            rdata_q <= 16'h0000;
            int_s1  <= 1'b0;
            int_s2  <= 1'b0;
            int_s3  <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            if (accept) begin
                sel_l   <= gnt_sel;
                wr_l    <= gnt_sel ? req1_write : req0_write;
                addr_l  <= gnt_sel ? req1_addr  : req0_addr;
                wdata_l <= gnt_sel ? req1_wdata : req0_wdata;
            end
            // Sample on the last strobe cycle so the chip has had the full strobe to drive DATA.
            if ((state == ST_STROBE) && (cnt == '0) && !wr_l && !soft_reset) begin
                rdata_q <= hpi.hpi_data_in;
            end
            int_s1 <= hpi.hpi_int;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
            int_q  <= int_s2 & ~int_s3;
        end
    end
endmodule

// File: tb/tb_cy7c67200_hpi_sequencer.sv
// tb/tb_cy7c67200_hpi_sequencer.sv - scoreboard testbench for cy7c67200_hpi_sequencer
import cy7c_hpi_pkg::*;

module tb_cy7c67200_hpi_sequencer;
    logic        clk;
    logic        reset, soft_reset;
    logic        req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [1:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [1:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic [15:0] rdata;
    logic        busy, int_pulse;
    logic [15:0] model_rdata;
    logic        int_drv;
    logic [1:0]  wr_addr_seen;
    logic [15:0] wr_data_seen;

    int tests = 0;
    int failed = 0;
    int proto_viol = 0;

    typedef struct {
        int          id;
        logic [15:0] data;
    } rd_t;

    int  exp_gnt_q[$];
    rd_t exp_rd_q[$];

    cy7c67200_hpi_sequencer_if hpi();

    cy7c67200_hpi_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .soft_reset  (soft_reset),
        .req0_valid  (req0_valid),
        .req0_write  (req0_write),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req1_valid  (req1_valid),
        .req1_write  (req1_write),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .rdata       (rdata),
        .busy        (busy),
        .int_pulse   (int_pulse),
        .hpi         (hpi.master)
    );

    // Chip model: drives read data only while RD_N and CS_N are low, records writes.
    assign hpi.hpi_data_in = (!hpi.hpi_rd_n && !hpi.hpi_cs_n) ? model_rdata : 16'h0000;
    assign hpi.hpi_int     = int_drv;

    always @(posedge clk) begin
        if (!hpi.hpi_wr_n && !hpi.hpi_cs_n) begin
            wr_addr_seen <= hpi.hpi_addr;
            wr_data_seen <= hpi.hpi_data_out;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a ready or rvalid pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (!hpi.hpi_rd_n && !hpi.hpi_wr_n) proto_viol++;
            if (hpi.hpi_data_oe && (!hpi.hpi_rd_n || hpi.hpi_cs_n)) proto_viol++;
            if (req0_ready && req1_ready) begin
                check("dual_ready", 32'd1, 32'd0);
            end else if (req0_ready || req1_ready) begin
                if (exp_gnt_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_ready: got ready on req%0d, expected none", req1_ready ? 1 : 0);
                end else begin
                    check("grant_id", 32'(req1_ready), 32'(exp_gnt_q.pop_front()));
                end
            end
            if (req0_rvalid && req1_rvalid) begin
                check("dual_rvalid", 32'd1, 32'd0);
            end else if (req0_rvalid || req1_rvalid) begin
                if (exp_rd_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_rvalid: got rvalid on req%0d, expected none", req1_rvalid ? 1 : 0);
                end else begin
                    rd_t e;
                    e = exp_rd_q.pop_front();
                    check("rvalid_id", 32'(req1_rvalid), 32'(e.id));
                    check("rdata", 32'(rdata), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_ready(input int id);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) return;
            n++;
            if (n > 40) begin
                tests++;
                failed++;
                $display("FAIL ready_timeout: got no ready on req%0d, expected one within 40 cycles", id);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        failed++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        int low, ipc, cs_lo, wr_lo, rd_lo, bad, oe_cnt, rv_cnt, g0, g1, n, cyc, pos;
        int tstamp[4];
        logic drop0, drop1;

        reset = 1'b1; soft_reset = 1'b0; int_drv = 1'b0; model_rdata = 16'h0000;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 2'd0; req0_wdata = 16'h0000;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 16'h0000;

        // Reset state
        @(negedge clk);
        check("rst_cs_n",  32'(hpi.hpi_cs_n), 32'd1);
        check("rst_rd_n",  32'(hpi.hpi_rd_n), 32'd1);
        check("rst_wr_n",  32'(hpi.hpi_wr_n), 32'd1);
        check("rst_rst_n", 32'(hpi.hpi_rst_n), 32'd0);
        check("rst_oe",    32'(hpi.hpi_data_oe), 32'd0);
        check("rst_addr",  32'(hpi.hpi_addr), 32'd0);
        check("rst_dout",  32'(hpi.hpi_data_out), 32'd0);
        check("rst_busy",  32'(busy), 32'd1);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_int",   32'(int_pulse), 32'd0);

        // RST_HOLD: requests and INT must be ignored
        reset = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = HPI_REG_MAILBOX; req0_wdata = 16'h5555;
        low = 0; ipc = 0;
        while (hpi.hpi_rst_n === 1'b0 && low < 40) begin
            low++;
            if (int_pulse) ipc++;
            if (low == 3)  int_drv = 1'b1;
            if (low == 10) req0_valid = 1'b0;
            if (low == 13) int_drv = 1'b0;
            @(negedge clk);
        end
        check("rst_hold_len", 32'(low), 32'd16);
        check("int_in_hold", 32'(ipc), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Write: req0 addr=2 data=0x1234
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = HPI_REG_ADDRESS; req0_wdata = 16'h1234;
        exp_gnt_q.push_back(0);
        wait_ready(0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        cs_lo = 0; wr_lo = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!hpi.hpi_cs_n) cs_lo++;
            if (!hpi.hpi_wr_n) begin
                wr_lo++;
                if (hpi.hpi_data_out !== 16'h1234 || hpi.hpi_data_oe !== 1'b1 || hpi.hpi_addr !== 2'd2) bad++;
            end
        end
        check("wr_cs_low", 32'(cs_lo), 32'd6);
        check("wr_strobe_low", 32'(wr_lo), 32'd4);
        check("wr_bus_bad", 32'(bad), 32'd0);
        check("wr_chip_data", 32'(wr_data_seen), 32'h1234);
        check("wr_chip_addr", 32'(wr_addr_seen), 32'd2);

        // Read: req1 addr=0, chip returns 0xBEEF
        model_rdata = 16'hBEEF;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = HPI_REG_DATA;
        exp_gnt_q.push_back(1);
        exp_rd_q.push_back('{id: 1, data: 16'hBEEF});
        wait_ready(1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        oe_cnt = 0; rv_cnt = 0; rd_lo = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hpi.hpi_data_oe) oe_cnt++;
            if (req1_rvalid) rv_cnt++;
            if (!hpi.hpi_rd_n) rd_lo++;
        end
        check("rd_oe_high", 32'(oe_cnt), 32'd0);
        check("rd_rvalid_cnt", 32'(rv_cnt), 32'd1);
        check("rd_strobe_low", 32'(rd_lo), 32'd4);
        check("rd_rdata_held", 32'(rdata), 32'hBEEF);

        // Both requesters valid: grants alternate 0,1,0,1, 7 cycles apart
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = HPI_REG_MAILBOX; req0_wdata = 16'h00A0;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = HPI_REG_STATUS;  req1_wdata = 16'h00B1;
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
        g0 = 0; g1 = 0; n = 0; cyc = 0;
        while (cyc < 60 && n < 4) begin
            @(negedge clk);
            cyc++;
            drop0 = 1'b0; drop1 = 1'b0;
            if (req0_ready) begin tstamp[n] = cyc; n++; g0++; if (g0 == 2) drop0 = 1'b1; end
            if (req1_ready && n < 4) begin tstamp[n] = cyc; n++; g1++; if (g1 == 2) drop1 = 1'b1; end
            @(posedge clk); #1;
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("alt_grants", 32'(n), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < n) check($sformatf("alt_gap%0d", i), 32'(tstamp[i] - tstamp[i-1]), 32'd7);
        end
        repeat (8) @(negedge clk);

        // soft_reset during the 2nd strobe cycle of a read
        model_rdata = 16'hCAFE;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = HPI_REG_STATUS;
        exp_gnt_q.push_back(1);
        wait_ready(1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        soft_reset = 1'b1;
        @(negedge clk);
        check("abort_rd_active", 32'(hpi.hpi_rd_n), 32'd0);
        @(posedge clk); #1;
        soft_reset = 1'b0;
        @(negedge clk);
        check("abort_cs_n", 32'(hpi.hpi_cs_n), 32'd1);
        check("abort_rd_n", 32'(hpi.hpi_rd_n), 32'd1);
        check("abort_wr_n", 32'(hpi.hpi_wr_n), 32'd1);
        check("abort_oe", 32'(hpi.hpi_data_oe), 32'd0);
        low = 0;
        while (hpi.hpi_rst_n === 1'b0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check("soft_rst_len", 32'(low), 32'd16);
        check("abort_rdata_kept", 32'(rdata), 32'hBEEF);

        // INT rising edge held 10 cycles: one pulse, 3 cycles later
        int_drv = 1'b1;
        ipc = 0; pos = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (int_pulse) begin ipc++; pos = i; end
        end
        int_drv = 1'b0;
        check("int_pulse_cnt", 32'(ipc), 32'd1);
        check("int_pulse_pos", 32'(pos), 32'd3);

        repeat (4) @(negedge clk);
        check("gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);
        check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check("protocol_viol", 32'(proto_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
